// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the dual-clock FIFO.
// Functions work on a fixed 32-bit word; callers size-cast in and out.
package fifo_pkg;

    localparam int PTR_FN_W = 32;

    typedef logic [PTR_FN_W-1:0] ptr_word_t;

    typedef enum logic {
        OUT_IDLE  = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    // One extra wrap bit distinguishes full from empty.
    function automatic int ptr_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < PTR_FN_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ptr.sv
// Read pointer (binary and Gray), empty compare and fill-level register
// for the read side of the dual-clock FIFO.
module fifo_rd_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_pop,
    input  logic [ADDR_BITS:0]   i_wr_ptr_gray_sync,
    output logic [ADDR_BITS-1:0] o_rd_addr,
    output logic [ADDR_BITS:0]   o_rd_ptr_gray,
    output logic                 o_empty,
    output logic [ADDR_BITS:0]   o_level
);

    localparam int PTR_W = ptr_width(ADDR_BITS);

    logic [PTR_W-1:0] rd_bin_p0;
    logic [PTR_W-1:0] rd_bin_next;
    logic [PTR_W-1:0] rd_gray;
    logic [PTR_W-1:0] wr_bin;

    assign rd_bin_next = i_pop ? rd_bin_p0 + PTR_W'(1) : rd_bin_p0;
    assign rd_gray     = PTR_W'(bin2gray(PTR_FN_W'(rd_bin_p0)));
    assign wr_bin      = PTR_W'(gray2bin(PTR_FN_W'(i_wr_ptr_gray_sync)));

    // Empty compares in Gray space so a stale synced pointer only ever
    // under-reports available words.
    assign o_empty   = (rd_gray == i_wr_ptr_gray_sync);
    assign o_rd_addr = rd_bin_p0[ADDR_BITS-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_bin_p0     <= '0;
            o_rd_ptr_gray <= '0;
            o_level       <= '0;
        end else begin
            rd_bin_p0     <= rd_bin_next;
            o_rd_ptr_gray <= PTR_W'(bin2gray(PTR_FN_W'(rd_bin_next)));
            o_level       <= wr_bin - rd_bin_next;
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// Read-domain controller of the dual-clock Ethernet FIFO: drains the FWFT
// RAM into an AXI-Stream master through a single output register.
module fifo_axis_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_BITS  = $clog2(MEM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [ADDR_BITS:0]    i_wr_ptr_gray_sync,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [ADDR_BITS-1:0]  o_rd_addr,
    output logic                  o_rd_en,
    output logic [ADDR_BITS:0]    o_rd_ptr_gray,
    output logic                  o_empty,
    output logic [ADDR_BITS:0]    o_level,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready
);

    out_state_t            state_q;
    out_state_t            state_d;
    logic                  can_load;
    logic                  pop;
    logic                  empty;
    logic [DATA_WIDTH-1:0] data_p1;

    fifo_rd_ptr #(
        .ADDR_BITS (ADDR_BITS)
    ) u_rd_ptr (
        .i_clk              (i_clk),
        .i_reset_n          (i_reset_n),
        .i_pop              (pop),
        .i_wr_ptr_gray_sync (i_wr_ptr_gray_sync),
        .o_rd_addr          (o_rd_addr),
        .o_rd_ptr_gray      (o_rd_ptr_gray),
        .o_empty            (empty),
        .o_level            (o_level)
    );

    // Loading while the sink takes the current beat keeps full throughput.
    assign can_load = (state_q == OUT_IDLE) || i_m_tready;
    assign pop      = !empty && can_load;

    assign o_rd_en    = pop;
    assign o_empty    = empty;
    assign o_m_tvalid = (state_q == OUT_VALID);
    assign o_m_tdata  = data_p1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_IDLE:  if (pop) state_d = OUT_VALID;
            OUT_VALID: if (i_m_tready && !pop) state_d = OUT_IDLE;
            default:   state_d = OUT_IDLE;
        endcase
    end

    // Output register stage (p1)
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= OUT_IDLE;
            data_p1 <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                data_p1 <= i_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader with a behavioural RAM/write side.
module tb_fifo_axis_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int AB    = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AB:0]   wr_gray;
    logic [DW-1:0] rd_data;
    logic [AB-1:0] rd_addr;
    logic          rd_en;
    logic [AB:0]   rd_ptr_gray;
    logic          empty;
    logic [AB:0]   level;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    logic [DW-1:0] mem [DEPTH];
    logic [AB:0]   wr_bin;
    logic [DW-1:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev  = '0;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    fifo_axis_reader #(
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (reset_n),
        .i_wr_ptr_gray_sync (wr_gray),
        .i_rd_data          (rd_data),
        .o_rd_addr          (rd_addr),
        .o_rd_en            (rd_en),
        .o_rd_ptr_gray      (rd_ptr_gray),
        .o_empty            (empty),
        .o_level            (level),
        .o_m_tdata          (tdata),
        .o_m_tvalid         (tvalid),
        .i_m_tready         (tready)
    );

    function automatic logic [AB:0] to_gray(input logic [AB:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wr_bin[AB-1:0]] = d;
        wr_bin  = wr_bin + 1'b1;
        wr_gray = to_gray(wr_bin);
        exp_q.push_back(d);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        tready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            step(1);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        step(2);
    endtask

    task automatic check_idle(input string name);
        check({name, "_tvalid"}, {31'd0, tvalid}, 0);
        check({name, "_empty"}, {31'd0, empty}, 1);
        check({name, "_level"}, {25'd0, level}, 0);
        check({name, "_gray"}, {25'd0, rd_ptr_gray}, {25'd0, to_gray(wr_bin)});
        check({name, "_addr"}, {26'd0, rd_addr}, {26'd0, wr_bin[AB-1:0]});
    endtask

    // Monitor: scores every accepted beat and AXI-S stability under stall.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_tvalid", {31'd0, tvalid}, 1);
                check("hold_tdata", {24'd0, tdata}, {24'd0, data_prev});
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {24'd0, tdata}, 32'hFFFF_FFFF);
                end else begin
                    check("beat_data", {24'd0, tdata}, {24'd0, exp_q.pop_front()});
                end
            end
            stall_prev = tvalid && !tready;
            data_prev  = tdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        reset_n = 1'b0;
        tready  = 1'b0;
        wr_bin  = '0;
        wr_gray = '0;
        step(3);

        // reset state
        check("rst_tvalid", {31'd0, tvalid}, 0);
        check("rst_empty", {31'd0, empty}, 1);
        check("rst_level", {25'd0, level}, 0);
        check("rst_gray", {25'd0, rd_ptr_gray}, 0);
        check("rst_addr", {26'd0, rd_addr}, 0);
        check("rst_tdata", {24'd0, tdata}, 0);
        reset_n = 1'b1;
        step(2);

        // single word latency
        tready = 1'b1;
        write_word(8'hA5);
        @(negedge clk);
        check("lat_rd_en", {31'd0, rd_en}, 1);
        step(1);
        check("lat_tvalid", {31'd0, tvalid}, 1);
        check("lat_tdata", {24'd0, tdata}, 32'hA5);
        check("lat_gray", {25'd0, rd_ptr_gray}, 1);
        check("lat_level", {25'd0, level}, 0);
        step(2);
        check_idle("one");

        // 16-word burst, no bubbles
        for (int i = 0; i < 16; i++) write_word(8'(i));
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("burst_tvalid", {31'd0, tvalid}, 1);
        end
        @(negedge clk);
        check("burst_end_tvalid", {31'd0, tvalid}, 0);
        step(1);
        check("burst_q", exp_q.size(), 0);

        // 16-word burst with tready low for cycles 3..7
        for (int i = 0; i < 16; i++) write_word(8'(i));
        for (int c = 0; c < 26; c++) begin
            tready = !(c >= 3 && c <= 7);
            step(1);
        end
        wait_drain("stall");
        check_idle("stall");

        // fill the RAM completely while the output register holds a beat
        tready = 1'b0;
        write_word(8'($urandom));
        step(3);
        for (int i = 0; i < DEPTH; i++) write_word(8'($urandom));
        step(3);
        check("full_level", {25'd0, level}, DEPTH);
        check("full_empty", {31'd0, empty}, 0);
        check("full_tvalid", {31'd0, tvalid}, 1);
        wait_drain("full");
        check_idle("full");
        for (int i = 0; i < 10; i++) write_word(8'($urandom));
        wait_drain("wrap");
        check_idle("wrap");

        // randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            tready = 1'($urandom);
            if ($urandom_range(0, 2) != 0 && exp_q.size() < DEPTH)
                write_word(8'($urandom));
            step(1);
        end
        wait_drain("rand");
        check_idle("rand");

        // reset in the middle of a burst
        for (int i = 0; i < 20; i++) write_word(8'($urandom));
        step(5);
        check("mid_tvalid_pre", {31'd0, tvalid}, 1);
        reset_n = 1'b0;
        wr_bin  = '0;
        wr_gray = '0;
        exp_q.delete();
        step(1);
        check("mid_tvalid", {31'd0, tvalid}, 0);
        check("mid_tdata", {24'd0, tdata}, 0);
        check("mid_addr", {26'd0, rd_addr}, 0);
        check("mid_gray", {25'd0, rd_ptr_gray}, 0);
        step(1);
        reset_n = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) write_word(8'(8'h50 + i));
        wait_drain("resume");
        check_idle("resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
